// File: rtl/br_predict_unit.sv
`default_nettype none
// ============================================================================
// Module : br_predict_unit
// Direct-mapped BTB/BHT with saturating direction counters and circular RAS.
// Rev    : 1.0
// ============================================================================
module br_predict_unit #(
  parameter int ENTRIES   = 16,
  parameter int RAS_DEPTH = 4,
  parameter int CTR_W     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] f_pc,
  output logic        f_pred_taken,
  output logic [31:0] f_pred_target,
  input  logic        r_valid,
  input  logic [31:0] r_pc,
  input  logic [1:0]  r_kind,
  input  logic        r_taken,
  input  logic [31:0] r_target,
  input  logic        r_pred_taken,
  input  logic [31:0] r_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_resolved,
  output logic [31:0] stat_mispred
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [CTR_W-1:0] CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CTR_WEAK_T  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_MAX     = '1;
  localparam logic [1:0]       KIND_COND   = 2'b00;
  localparam logic [1:0]       KIND_CALL   = 2'b10;
  localparam logic [1:0]       KIND_RET    = 2'b11;

  logic             valid_q [ENTRIES];
  logic             valid_d [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [TAG_W-1:0] tag_d   [ENTRIES];
  logic [1:0]       kind_q  [ENTRIES];
  logic [1:0]       kind_d  [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [31:0]      tgt_d   [ENTRIES];
  logic [CTR_W-1:0] ctr_q   [ENTRIES];
  logic [CTR_W-1:0] ctr_d   [ENTRIES];

  logic [31:0]      ras_q [RAS_DEPTH];
  logic [31:0]      ras_d [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             mispredict_q, mispredict_d;
  logic [31:0]      redirect_q, redirect_d;
  logic [31:0]      stat_res_q, stat_res_d;
  logic [31:0]      stat_mis_q, stat_mis_d;

  logic [IDX_W-1:0] f_idx, r_idx;
  logic             f_hit, r_hit;
  logic [PTR_W-1:0] top_ptr;
  logic [31:0]      hit_target;
  logic [31:0]      actual_next, pred_next;
  logic             unused_low_bits;

  assign unused_low_bits = ^{f_pc[1:0], r_pc[1:0]};

  assign f_idx   = f_pc[IDX_W+1:2];
  assign f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_pc[31:IDX_W+2]);
  assign r_idx   = r_pc[IDX_W+1:2];
  assign r_hit   = valid_q[r_idx] && (tag_q[r_idx] == r_pc[31:IDX_W+2]);
  // sp_q is the next write slot; the top of stack sits one below it, circularly.
  assign top_ptr = (sp_q == '0) ? PTR_W'(RAS_DEPTH - 1) : sp_q - PTR_W'(1);

  assign actual_next = r_taken      ? r_target      : r_pc + 32'd8;
  assign pred_next   = r_pred_taken ? r_pred_target : r_pc + 32'd8;

  always_comb begin
    f_pred_taken = 1'b0;
    hit_target   = tgt_q[f_idx];
    if (f_hit) begin
      case (kind_q[f_idx])
        KIND_COND: f_pred_taken = ctr_q[f_idx][CTR_W-1];
        KIND_RET: begin
          f_pred_taken = (cnt_q != '0);
          hit_target   = ras_q[top_ptr];
        end
        default:   f_pred_taken = 1'b1;
      endcase
    end
    f_pred_target = f_pred_taken ? hit_target : f_pc + 32'd4;
  end

  always_comb begin
    valid_d      = valid_q;
    tag_d        = tag_q;
    kind_d       = kind_q;
    tgt_d        = tgt_q;
    ctr_d        = ctr_q;
    ras_d        = ras_q;
    sp_d         = sp_q;
    cnt_d        = cnt_q;
    mispredict_d = r_valid && (actual_next != pred_next);
    redirect_d   = r_valid ? actual_next : redirect_q;
    stat_res_d   = stat_res_q + {31'd0, r_valid};
    stat_mis_d   = stat_mis_q + {31'd0, mispredict_d};

    // Not-taken misses never allocate, so cold branches do not evict live entries.
    if (r_valid && (r_taken || r_hit)) begin
      valid_d[r_idx] = 1'b1;
      tag_d[r_idx]   = r_pc[31:IDX_W+2];
      kind_d[r_idx]  = r_kind;
      if (r_kind != KIND_RET) begin
        tgt_d[r_idx] = r_target;
      end
      if (!r_hit) begin
        ctr_d[r_idx] = r_taken ? CTR_WEAK_T : CTR_WEAK_NT;
      end else if (r_taken) begin
        if (ctr_q[r_idx] != CTR_MAX) ctr_d[r_idx] = ctr_q[r_idx] + CTR_W'(1);
      end else begin
        if (ctr_q[r_idx] != '0) ctr_d[r_idx] = ctr_q[r_idx] - CTR_W'(1);
      end
    end

    if (r_valid && (r_kind == KIND_CALL)) begin
      ras_d[sp_q] = r_pc + 32'd8;
      sp_d        = (sp_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : sp_q + PTR_W'(1);
      if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (r_valid && (r_kind == KIND_RET) && (cnt_q != '0)) begin
      sp_d  = top_ptr;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        kind_q[i]  <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_WEAK_NT;
      end
      for (int j = 0; j < RAS_DEPTH; j++) begin
        ras_q[j] <= '0;
      end
      sp_q         <= '0;
      cnt_q        <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      stat_res_q   <= '0;
      stat_mis_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      kind_q       <= kind_d;
      tgt_q        <= tgt_d;
      ctr_q        <= ctr_d;
      ras_q        <= ras_d;
      sp_q         <= sp_d;
      cnt_q        <= cnt_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      stat_res_q   <= stat_res_d;
      stat_mis_q   <= stat_mis_d;
    end
  end

  assign mispredict    = mispredict_q;
  assign redirect_pc   = redirect_q;
  assign stat_resolved = stat_res_q;
  assign stat_mispred  = stat_mis_q;

endmodule
`default_nettype wire

// File: tb/tb_br_predict_unit.sv
`default_nettype none
// Testbench for br_predict_unit: directed vectors, behavioural reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_br_predict_unit;
  localparam int ENTRIES   = 16;
  localparam int RAS_DEPTH = 4;
  localparam int CTR_W     = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] f_pc = '0;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;
  logic        r_valid = 1'b0;
  logic [31:0] r_pc = '0;
  logic [1:0]  r_kind = '0;
  logic        r_taken = 1'b0;
  logic [31:0] r_target = '0;
  logic        r_pred_taken = 1'b0;
  logic [31:0] r_pred_target = '0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispred;

  always #5 clk = ~clk;

  br_predict_unit #(.ENTRIES(ENTRIES), .RAS_DEPTH(RAS_DEPTH), .CTR_W(CTR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_pc(f_pc), .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
    .r_valid(r_valid), .r_pc(r_pc), .r_kind(r_kind), .r_taken(r_taken),
    .r_target(r_target), .r_pred_taken(r_pred_taken), .r_pred_target(r_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_v   [ENTRIES];
  logic [31:0] m_tag [ENTRIES];
  int          m_kind[ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int          m_ctr [ENTRIES];
  logic [31:0] m_ras [$];
  bit          m_misp;
  logic [31:0] m_redir, m_res, m_mis;

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_v[i] = 0; m_tag[i] = '0; m_kind[i] = 0; m_tgt[i] = '0;
      m_ctr[i] = (1 << (CTR_W - 1)) - 1;
    end
    m_ras.delete();
    m_misp = 0; m_redir = '0; m_res = '0; m_mis = '0;
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int i;
    i  = int'((pc >> 2) % ENTRIES);
    t  = 0;
    tg = pc + 32'd4;
    if (m_v[i] && m_tag[i] == (pc >> (2 + $clog2(ENTRIES)))) begin
      if (m_kind[i] == 0) begin
        t = m_ctr[i] >= (1 << (CTR_W - 1));
        if (t) tg = m_tgt[i];
      end else if (m_kind[i] == 3) begin
        if (m_ras.size() > 0) begin t = 1; tg = m_ras[$]; end
      end else begin
        t = 1; tg = m_tgt[i];
      end
    end
  endfunction

  function automatic void m_step();
    logic [31:0] act, prd;
    int i, cmax;
    bit hit;
    if (!r_valid) begin m_misp = 0; return; end
    act     = r_taken ? r_target : r_pc + 32'd8;
    prd     = r_pred_taken ? r_pred_target : r_pc + 32'd8;
    m_misp  = (act != prd);
    m_redir = act;
    m_res   = m_res + 1;
    if (m_misp) m_mis = m_mis + 1;
    i    = int'((r_pc >> 2) % ENTRIES);
    hit  = m_v[i] && m_tag[i] == (r_pc >> (2 + $clog2(ENTRIES)));
    cmax = (1 << CTR_W) - 1;
    if (r_taken || hit) begin
      if (hit) begin
        m_ctr[i] = m_ctr[i] + (r_taken ? 1 : -1);
        if (m_ctr[i] > cmax) m_ctr[i] = cmax;
        if (m_ctr[i] < 0) m_ctr[i] = 0;
      end else begin
        m_ctr[i] = r_taken ? (1 << (CTR_W - 1)) : (1 << (CTR_W - 1)) - 1;
      end
      m_v[i]    = 1;
      m_tag[i]  = r_pc >> (2 + $clog2(ENTRIES));
      m_kind[i] = int'(r_kind);
      if (r_kind != 2'b11) m_tgt[i] = r_target;
    end
    if (r_kind == 2'b10) begin
      m_ras.push_back(r_pc + 32'd8);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
    end else if (r_kind == 2'b11 && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  bit          e_t;
  logic [31:0] e_tg;
  bit          cmp_en = 1'b1;

  always @(negedge clk) begin
    if (cmp_en) begin
      m_lookup(f_pc, e_t, e_tg);
      chk("model_pred_taken",  {31'd0, f_pred_taken}, {31'd0, e_t});
      chk("model_pred_target", f_pred_target, e_tg);
      chk("model_mispredict",  {31'd0, mispredict}, {31'd0, m_misp});
      chk("model_redirect",    redirect_pc, m_redir);
      chk("model_stat_res",    stat_resolved, m_res);
      chk("model_stat_mis",    stat_mispred, m_mis);
    end
  end

  // ---------------- stimulus ----------------
  task automatic resolve(input logic [1:0] k, input logic [31:0] pc, input logic t,
                         input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
    r_valid = 1'b1; r_kind = k; r_pc = pc; r_taken = t; r_target = tg;
    r_pred_taken = pt; r_pred_target = ptg;
    @(posedge clk); #2;
    r_valid = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic t, input logic [31:0] tg);
    f_pc = pc;
    #1;
    chk({name, "_taken"},  {31'd0, f_pred_taken}, {31'd0, t});
    chk({name, "_target"}, f_pred_target, tg);
    @(posedge clk); #2;
  endtask

  logic [31:0] pop_exp [4];

  initial begin
    pop_exp = '{32'h5008, 32'h4008, 32'h3008, 32'h2008};
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    look("cold", 32'h0040_0010, 1'b0, 32'h0040_0014);
    chk("cold_stat_res", stat_resolved, 32'd0);
    chk("cold_stat_mis", stat_mispred, 32'd0);
    chk("cold_redirect", redirect_pc, 32'd0);

    resolve(2'b00, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0);
    chk("alloc_misp", {31'd0, mispredict}, 32'd1);
    chk("alloc_redirect", redirect_pc, 32'h0040_0040);
    chk("alloc_stat_mis", stat_mispred, 32'd1);
    look("alloc", 32'h0040_0010, 1'b1, 32'h0040_0040);

    resolve(2'b00, 32'h0040_0010, 1'b0, 32'h0040_0040, 1'b1, 32'h0040_0040);
    chk("nt1_misp", {31'd0, mispredict}, 32'd1);
    chk("nt1_redirect", redirect_pc, 32'h0040_0018);
    resolve(2'b00, 32'h0040_0010, 1'b0, 32'h0040_0040, 1'b0, 32'h0);
    chk("nt2_misp", {31'd0, mispredict}, 32'd0);
    look("nt2", 32'h0040_0010, 1'b0, 32'h0040_0014);

    resolve(2'b10, 32'h0040_0100, 1'b1, 32'h0040_0800, 1'b0, 32'h0);
    resolve(2'b11, 32'h0040_0820, 1'b1, 32'h0040_0108, 1'b0, 32'h0);
    chk("ret_redirect", redirect_pc, 32'h0040_0108);
    resolve(2'b10, 32'h0040_0100, 1'b1, 32'h0040_0800, 1'b1, 32'h0040_0800);
    look("ret_hit", 32'h0040_0820, 1'b1, 32'h0040_0108);
    look("call_hit", 32'h0040_0100, 1'b1, 32'h0040_0800);

    resolve(2'b01, 32'h0040_0204, 1'b1, 32'h0040_0300, 1'b0, 32'h0);
    look("jump_hit", 32'h0040_0204, 1'b1, 32'h0040_0300);

    for (int k = 1; k <= 5; k++) begin
      resolve(2'b10, 32'(k) << 12, 1'b1, 32'h0000_9000, 1'b0, 32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      look("ras_top", 32'h0040_0820, 1'b1, pop_exp[k]);
      resolve(2'b11, 32'h0040_0820, 1'b1, pop_exp[k], 1'b1, pop_exp[k]);
      chk("pop_misp", {31'd0, mispredict}, 32'd0);
    end
    resolve(2'b11, 32'h0040_0820, 1'b1, 32'h0000_2008, 1'b0, 32'h0);
    look("ras_empty", 32'h0040_0820, 1'b0, 32'h0040_0824);

    resolve(2'b00, 32'h0040_0050, 1'b1, 32'h0040_0090, 1'b0, 32'h0);
    look("evicted", 32'h0040_0010, 1'b0, 32'h0040_0014);
    look("evictor", 32'h0040_0050, 1'b1, 32'h0040_0090);
    resolve(2'b00, 32'h0040_0050, 1'b1, 32'h0040_0090, 1'b1, 32'h0040_0090);
    resolve(2'b00, 32'h0040_0050, 1'b1, 32'h0040_0090, 1'b1, 32'h0040_0090);
    resolve(2'b00, 32'h0040_0050, 1'b0, 32'h0040_0090, 1'b1, 32'h0040_0090);
    chk("sat_misp", {31'd0, mispredict}, 32'd1);
    chk("sat_redirect", redirect_pc, 32'h0040_0058);
    look("sat_still_taken", 32'h0040_0050, 1'b1, 32'h0040_0090);

    // asynchronous reset with an update in flight
    f_pc = 32'h0040_0050;
    r_valid = 1'b1; r_kind = 2'b10; r_pc = 32'h0040_0300; r_taken = 1'b1;
    r_target = 32'h0040_0700; r_pred_taken = 1'b0; r_pred_target = 32'h0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_misp", {31'd0, mispredict}, 32'd0);
    chk("arst_redirect", redirect_pc, 32'd0);
    chk("arst_stat_res", stat_resolved, 32'd0);
    chk("arst_stat_mis", stat_mispred, 32'd0);
    chk("arst_pred_taken", {31'd0, f_pred_taken}, 32'd0);
    chk("arst_pred_target", f_pred_target, 32'h0040_0054);
    @(posedge clk); #2;
    r_valid = 1'b0;
    rst_n = 1'b1;
    look("cold2", 32'h0040_0300, 1'b0, 32'h0040_0304);
    chk("cold2_stat_res", stat_resolved, 32'd0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
